// File: rtl/cordic_job_sequencer_if.sv
// Job, core and result channels of the CORDIC job sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface cordic_job_sequencer_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int ANGLE_WIDTH     = 16,
  parameter int ITERATION_WIDTH = 4,
  parameter int FIFO_DEPTH      = 4
);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      in_x;
  logic [DATA_WIDTH-1:0]      in_y;
  logic [ITERATION_WIDTH-1:0] in_n;

  logic                       core_start;
  logic [DATA_WIDTH-1:0]      core_x;
  logic [DATA_WIDTH-1:0]      core_y;
  logic [ITERATION_WIDTH-1:0] core_n;
  logic                       core_done;
  logic [DATA_WIDTH-1:0]      core_mag;
  logic [ANGLE_WIDTH-1:0]     core_angle;

  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH-1:0]      out_mag;
  logic [ANGLE_WIDTH-1:0]     out_angle;

  logic [COUNT_WIDTH-1:0]     fifo_count;
  logic                       busy;

  modport slave (
    input  in_valid, in_x, in_y, in_n,
    output in_ready,
    output core_start, core_x, core_y, core_n,
    input  core_done, core_mag, core_angle,
    output out_valid, out_mag, out_angle,
    input  out_ready,
    output fifo_count, busy
  );

  modport master (
    output in_valid, in_x, in_y, in_n,
    input  in_ready,
    input  core_start, core_x, core_y, core_n,
    output core_done, core_mag, core_angle,
    input  out_valid, out_mag, out_angle,
    output out_ready,
    input  fifo_count, busy
  );
endinterface

// File: rtl/cordic_job_sequencer.sv
// Queues (x, y, n) jobs, issues them one at a time to the CORDIC core and
// holds each magnitude/angle result in a valid/ready output register.
module cordic_job_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int ANGLE_WIDTH     = 16,
  parameter int ITERATION_WIDTH = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input logic                    clk,
  input logic                    rst,
  cordic_job_sequencer_if.slave  bus
);
  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;
  localparam int JOB_WIDTH   = 2 * DATA_WIDTH + ITERATION_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_RUN,
    ST_STALL
  } state_t;

  state_t                     r_state;
  logic [JOB_WIDTH-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]       r_wr_ptr;
  logic [PTR_WIDTH-1:0]       r_rd_ptr;
  logic [COUNT_WIDTH-1:0]     r_count;
  logic                       r_reissue;
  logic                       r_ack_wait;

  logic                       r_core_start;
  logic [DATA_WIDTH-1:0]      r_core_x;
  logic [DATA_WIDTH-1:0]      r_core_y;
  logic [ITERATION_WIDTH-1:0] r_core_n;

  logic                       r_out_valid;
  logic [DATA_WIDTH-1:0]      r_out_mag;
  logic [ANGLE_WIDTH-1:0]     r_out_angle;

  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_out_take;
  logic w_capture;

  // Acceptance depends on the registered count only: no bypass when full.
  assign w_in_ready = (r_count < COUNT_WIDTH'(FIFO_DEPTH));
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = (r_state == ST_ISSUE) && !r_reissue;
  assign w_out_take = r_out_valid && bus.out_ready;
  assign w_capture  = ((r_state == ST_RUN) && bus.core_done &&
                       (!r_out_valid || bus.out_ready)) ||
                      ((r_state == ST_STALL) && bus.out_ready);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_x, bus.in_y, bus.in_n};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
        2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_reissue    <= 1'b0;
      r_ack_wait   <= 1'b0;
      r_core_start <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_n     <= '0;
      r_out_valid  <= 1'b0;
      r_out_mag    <= '0;
      r_out_angle  <= '0;
    end else begin
      r_core_start <= 1'b0;

      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_mag   <= bus.core_mag;
        r_out_angle <= bus.core_angle;
      end else if (w_out_take) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          // Operands are loaded on entry so they are visible with the start pulse.
          if ((r_count != '0) && bus.core_done) begin
            r_state                          <= ST_ISSUE;
            r_core_start                     <= 1'b1;
            r_reissue                        <= 1'b0;
            {r_core_x, r_core_y, r_core_n}   <= r_mem[r_rd_ptr];
          end
        end
        ST_ISSUE: begin
          r_state    <= ST_ACK;
          r_ack_wait <= 1'b0;
        end
        ST_ACK: begin
          if (!bus.core_done) begin
            r_state <= ST_RUN;
          end else if (r_ack_wait) begin
            // Core never left idle: pulse start again with the held operands.
            r_state      <= ST_ISSUE;
            r_core_start <= 1'b1;
            r_reissue    <= 1'b1;
          end else begin
            r_ack_wait <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.core_done) begin
            r_state <= w_capture ? ST_IDLE : ST_STALL;
          end
        end
        ST_STALL: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.core_start = r_core_start;
  assign bus.core_x     = r_core_x;
  assign bus.core_y     = r_core_y;
  assign bus.core_n     = r_core_n;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_mag    = r_out_mag;
  assign bus.out_angle  = r_out_angle;
  assign bus.fifo_count = r_count;
  assign bus.busy       = (r_state != ST_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Directed bench for cordic_job_sequencer with a 10-cycle behavioural core
// whose result is mag = x + y, angle = n * 100.
module tb_cordic_job_sequencer;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_job_sequencer_if #(
    .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .ITERATION_WIDTH(IW), .FIFO_DEPTH(FD)
  ) bus ();

  cordic_job_sequencer #(
    .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .ITERATION_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core model; it can be told to ignore start pulses.
  logic          model_done;
  logic [3:0]    model_cnt;
  logic [DW-1:0] model_mag;
  logic [AW-1:0] model_angle;
  logic          hold_done;
  int            ignore_budget;
  int            ignored_cnt = 0;

  assign bus.core_done  = model_done && !hold_done;
  assign bus.core_mag   = model_mag;
  assign bus.core_angle = model_angle;

  always @(posedge clk) begin
    if (rst) begin
      model_done  <= 1'b1;
      model_cnt   <= '0;
      model_mag   <= '0;
      model_angle <= '0;
    end else if (bus.core_start && model_done) begin
      if (ignored_cnt < ignore_budget) begin
        ignored_cnt <= ignored_cnt + 1;
      end else begin
        model_done  <= 1'b0;
        model_cnt   <= 4'd10;
        model_mag   <= bus.core_x + bus.core_y;
        model_angle <= AW'(bus.core_n) * 16'd100;
      end
    end else if (!model_done) begin
      if (model_cnt == 4'd1) model_done <= 1'b1;
      model_cnt <= model_cnt - 4'd1;
    end
  end

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          start_cnt = 0;
  int          res_idx   = 0;
  int          n_checks  = 0;
  int          n_pass    = 0;

  always begin
    @(negedge clk);
    #2;
    if (bus.out_valid && bus.out_ready && !rst) begin
      got_q.push_back({bus.out_mag, bus.out_angle});
      $display("[%0t] result mag=%0d angle=%0d", $time, bus.out_mag, bus.out_angle);
    end
    if (bus.core_start) start_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic push_job(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [IW-1:0] n,
                          input logic [DW-1:0] emag, input logic [AW-1:0] eang, input bit expect_it);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_y = y;
    bus.in_n = n;
    while (!bus.in_ready && waited < 300) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check_eq("push_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    $display("[%0t] job x=%0d y=%0d n=%0d", $time, x, y, n);
    if (expect_it) exp_q.push_back({emag, eang});
  endtask

  task automatic wait_start(input string tag);
    int waited;
    waited = 0;
    while (!bus.core_start && waited < 100) begin
      tick();
      waited++;
    end
    check_eq(tag, {31'd0, bus.core_start}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int waited;
    waited = 0;
    while ((bus.busy || bus.out_valid) && waited < 1000) begin
      tick();
      waited++;
    end
    check_eq(tag, {30'd0, bus.busy, bus.out_valid}, 32'd0);
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    while (res_idx < got_q.size() && res_idx < exp_q.size()) begin
      check_eq(tag, got_q[res_idx], exp_q[res_idx]);
      res_idx++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int waited;
    bit issued;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_n = '0;
    bus.out_ready = 1'b1;
    hold_done = 1'b0;
    ignore_budget = 0;
    tick();
    do_reset();

    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_count", bus.fifo_count, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_core_start", {31'd0, bus.core_start}, 32'd0);
    check_eq("rst_core_x", bus.core_x, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_out_mag", bus.out_mag, 32'd0);

    // Single job
    s0 = start_cnt;
    push_job(16'd100, 16'd0, 4'd8, 16'd100, 16'd800, 1'b1);
    wait_start("t1_start");
    check_eq("t1_core_x", bus.core_x, 32'd100);
    check_eq("t1_core_n", bus.core_n, 32'd8);
    tick();
    check_eq("t1_start_pulse", {31'd0, bus.core_start}, 32'd0);
    check_eq("t1_core_x_held", bus.core_x, 32'd100);
    waited = 0;
    while (bus.core_done && waited < 50) begin tick(); waited++; end
    waited = 0;
    while (!bus.core_done && waited < 50) begin tick(); waited++; end
    check_eq("t1_valid_before", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check_eq("t1_valid_after", {31'd0, bus.out_valid}, 32'd1);
    check_eq("t1_mag", bus.out_mag, 32'd100);
    check_eq("t1_angle", bus.out_angle, 32'd800);
    tick();
    check_eq("t1_busy_done", {31'd0, bus.busy}, 32'd0);
    check_eq("t1_start_count", start_cnt - s0, 32'd1);
    check_results("t1_result");

    // FIFO full with core held busy
    hold_done = 1'b1;
    s0 = start_cnt;
    push_job(16'd1,    16'd2,  4'd1, 16'd3,   16'd100, 1'b1);
    push_job(16'd10,   16'd20, 4'd2, 16'd30,  16'd200, 1'b1);
    push_job(16'd300,  16'd4,  4'd3, 16'd304, 16'd300, 1'b1);
    push_job(16'hFFFB, 16'd15, 4'd4, 16'd10,  16'd400, 1'b1);
    check_eq("t2_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    check_eq("t2_count_full", bus.fifo_count, 32'd4);
    bus.in_valid = 1'b1;
    bus.in_x = 16'd0;
    bus.in_y = 16'd0;
    bus.in_n = 4'd0;
    hold_done = 1'b0;
    issued = 1'b0;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      if (bus.core_start) issued = 1'b1;
      tick();
      waited++;
    end
    check_eq("t2_pop_before_accept", {31'd0, issued}, 32'd1);
    check_eq("t2_count_after_pop", bus.fifo_count, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back({16'd0, 16'd0});
    check_eq("t2_count_refill", bus.fifo_count, 32'd4);
    wait_drain("t2_drain");
    check_eq("t2_start_count", start_cnt - s0, 32'd5);
    check_results("t2_result");

    // Output backpressure
    bus.out_ready = 1'b0;
    s0 = start_cnt;
    push_job(16'd50,   16'd50, 4'd5, 16'd100,  16'd500, 1'b1);
    push_job(16'd7,    16'd1,  4'd6, 16'd8,    16'd600, 1'b1);
    push_job(16'd1000, 16'd24, 4'd7, 16'd1024, 16'd700, 1'b1);
    tick(60);
    check_eq("t3_valid_held", {31'd0, bus.out_valid}, 32'd1);
    check_eq("t3_first_mag", bus.out_mag, 32'd100);
    check_eq("t3_first_angle", bus.out_angle, 32'd500);
    check_eq("t3_no_third_issue", start_cnt - s0, 32'd2);
    check_eq("t3_count_queued", bus.fifo_count, 32'd1);
    tick(5);
    check_eq("t3_mag_stable", bus.out_mag, 32'd100);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("t3_second_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("t3_second_mag", bus.out_mag, 32'd8);
    check_eq("t3_second_angle", bus.out_angle, 32'd600);
    tick(40);
    bus.out_ready = 1'b1;
    wait_drain("t3_drain");
    check_results("t3_result");

    // Simultaneous push/pop and pointer wrap
    do_reset();
    check_eq("t4_rst_count", bus.fifo_count, 32'd0);
    hold_done = 1'b1;
    push_job(16'd11, 16'd0, 4'd1, 16'd11, 16'd100, 1'b1);
    push_job(16'd12, 16'd0, 4'd2, 16'd12, 16'd200, 1'b1);
    hold_done = 1'b0;
    wait_start("t4_start");
    check_eq("t4_count_issue", bus.fifo_count, 32'd2);
    bus.in_valid = 1'b1;
    bus.in_x = 16'd13;
    bus.in_y = 16'd0;
    bus.in_n = 4'd3;
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back({16'd13, 16'd300});
    check_eq("t4_count_pushpop", bus.fifo_count, 32'd2);
    push_job(16'd14, 16'd0, 4'd4, 16'd14, 16'd400, 1'b1);
    push_job(16'd15, 16'd0, 4'd5, 16'd15, 16'd500, 1'b1);
    push_job(16'd16, 16'd0, 4'd6, 16'd16, 16'd600, 1'b1);
    wait_drain("t4_drain");
    check_results("t4_result");

    // Missed start pulse
    hold_done = 1'b1;
    s0 = start_cnt;
    push_job(16'd7, 16'd3, 4'd5, 16'd10, 16'd500, 1'b1);
    push_job(16'd9, 16'd9, 4'd9, 16'd18, 16'd900, 1'b1);
    ignore_budget = ignored_cnt + 1;
    hold_done = 1'b0;
    wait_start("t5_start");
    check_eq("t5_core_x", bus.core_x, 32'd7);
    check_eq("t5_count_issue", bus.fifo_count, 32'd2);
    tick();
    check_eq("t5_ack1_start", {31'd0, bus.core_start}, 32'd0);
    check_eq("t5_ack1_count", bus.fifo_count, 32'd1);
    tick();
    check_eq("t5_ack2_start", {31'd0, bus.core_start}, 32'd0);
    tick();
    check_eq("t5_repulse", {31'd0, bus.core_start}, 32'd1);
    check_eq("t5_repulse_x", bus.core_x, 32'd7);
    check_eq("t5_repulse_y", bus.core_y, 32'd3);
    check_eq("t5_repulse_n", bus.core_n, 32'd5);
    check_eq("t5_repulse_count", bus.fifo_count, 32'd1);
    wait_drain("t5_drain");
    check_eq("t5_start_count", start_cnt - s0, 32'd3);
    check_results("t5_result");

    // Reset during RUN with two jobs queued
    hold_done = 1'b1;
    push_job(16'd1, 16'd1, 4'd1, 16'd0, 16'd0, 1'b0);
    push_job(16'd2, 16'd2, 4'd2, 16'd0, 16'd0, 1'b0);
    push_job(16'd3, 16'd3, 4'd3, 16'd0, 16'd0, 1'b0);
    hold_done = 1'b0;
    wait_start("t6_start");
    waited = 0;
    while (bus.core_done && waited < 50) begin tick(); waited++; end
    tick();
    check_eq("t6_count_run", bus.fifo_count, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_count", bus.fifo_count, 32'd0);
    check_eq("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t6_core_start", {31'd0, bus.core_start}, 32'd0);
    check_eq("t6_core_x", bus.core_x, 32'd0);
    check_eq("t6_core_n", bus.core_n, 32'd0);
    check_eq("t6_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick(30);
    check_eq("t6_no_stale", got_q.size(), exp_q.size());
    push_job(16'd42, 16'd8, 4'd10, 16'd50, 16'd1000, 1'b1);
    wait_drain("t6_drain");
    check_results("t6_result");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cordic_job_sequencer.md
Name: cordic_job_sequencer

Overview:
Upstream/downstream wrapper stage for the CORDIC vectoring core. It accepts (x, y, n) jobs on a valid/ready input, buffers them in a small FIFO and issues them one at a time to the core's start/done handshake. It captures each finished magnitude/angle pair into a valid/ready output register. This decouples producers and consumers from the core's multi-cycle iteration latency.

Parameters:
DATA_WIDTH, 16, width of x, y and magnitude
ANGLE_WIDTH, 16, width of the angle result
ITERATION_WIDTH, 4, width of per-job iteration count n
FIFO_DEPTH, 4, job FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  job offered
in_ready  out  1  job FIFO can accept (count < FIFO_DEPTH)
in_x  in  DATA_WIDTH  signed x operand
in_y  in  DATA_WIDTH  signed y operand
in_n  in  ITERATION_WIDTH  iteration count for job
core_start  out  1  one-cycle start pulse to core
core_x  out  DATA_WIDTH  x of issued job, held until next issue
core_y  out  DATA_WIDTH  y of issued job, held until next issue
core_n  out  ITERATION_WIDTH  n of issued job, held until next issue
core_done  in  1  core idle/finished (high while core idle)
core_mag  in  DATA_WIDTH  core x result
core_angle  in  ANGLE_WIDTH  core z result
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_mag  out  DATA_WIDTH  captured magnitude
out_angle  out  ANGLE_WIDTH  captured angle
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
busy  out  1  state != IDLE or fifo_count != 0

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; FIFO pointers/count=0; core_start=0; core_x/y/n=0; out_valid=0; out_mag/out_angle=0. Reset mid-job discards FIFO contents and the in-flight job. No result is produced for it.
- FIFO push: in_valid && in_ready at posedge. in_ready is derived from the registered count only; there is no same-cycle bypass when full. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, ISSUE, ACK, RUN, STALL.
- IDLE: if fifo_count != 0 && core_done, go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): core_start=1. Pop the FIFO head into core_x/core_y/core_n, which are registered and visible this same cycle. Next state is ACK.
- ACK: wait for core_done=0, then go to RUN. If core_done stays 1 for 2 consecutive ACK cycles, return to ISSUE and re-pulse start with the same operands; this does not pop again.
- RUN: wait for core_done=1. On that cycle:
  - If !out_valid || out_ready: capture core_mag/core_angle, set out_valid=1, go to IDLE.
  - Otherwise go to STALL.
- STALL: the core holds its results while idle. When out_ready is high (output slot freeing this cycle), capture the core results and go to IDLE.
- Output: out_valid clears on out_valid && out_ready unless a capture occurs in the same cycle, in which case it stays 1 with the new data. Data is stable while out_valid && !out_ready.
- core_start is high only in ISSUE.
- Minimum job-to-job spacing is ISSUE + ACK + core latency + 1 IDLE cycle.
- Job results are returned in strict acceptance order.
- n=0 is passed through unchanged; the core performs its minimum iteration count.

Test Plan:
- Single job: push x=100, y=0, n=8 with out_ready=1 and a core model of 10 busy cycles. Require core_start high exactly 1 cycle, core_x=100/core_n=8 held, out_valid 1 cycle after done rises, out_mag=model result, busy=0 afterwards.
- FIFO full: push 5 jobs back-to-back with the core stalled (done=0). Require in_ready=0 after 4 accepted, fifo_count=4, and the 5th accepted only after the first ISSUE pop.
- Output backpressure: out_ready=0 while 2 jobs complete. Require the first result held stable, sequencer in STALL, no third ISSUE. Raising out_ready for 1 cycle must give results 1 then 2 in order with no loss.
- Simultaneous push/pop: with count=2, push on the ISSUE cycle. Require count stays 2 and correct wrap after 6 total jobs (pointer wrap at 4).
- Missed start: core model ignores the first start pulse (done stays 1). Require a re-pulse after 2 ACK cycles with identical operands, fifo_count decremented only once.
- Reset mid-operation: assert rst during RUN with 2 queued. Require all outputs/count=0 next cycle, no stale result after release, and a new job processed normally.
